// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the core datapath/memory.
// The sequencer is the master; the datapath side is the slave.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_zero;
  logic       alu_lt;
  logic       mem_ready;

  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       alu_src_b;
  logic [3:0] alu_ctrl;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       retire;
  logic       illegal;
  logic [2:0] state_o;

  modport master (
    input  opcode, funct3, funct7b5, alu_zero, alu_lt, mem_ready,
    output ir_write, pc_write, pc_sel, mem_req, mem_we, addr_sel,
           alu_src_b, alu_ctrl, reg_write, wb_sel, retire, illegal, state_o
  );

  modport slave (
    output opcode, funct3, funct7b5, alu_zero, alu_lt, mem_ready,
    input  ir_write, pc_write, pc_sel, mem_req, mem_we, addr_sel,
           alu_src_b, alu_ctrl, reg_write, wb_sel, retire, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory access and write-back,
// with a req/ready memory handshake guarded by a stall timeout (TIMEOUT in 2..65535).
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_JALR   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic       ir_write_c, pc_write_c, mem_req_c, mem_we_c, addr_sel_c;
  logic       alu_src_b_c, reg_write_c, retire_c, illegal_c;
  logic [1:0] pc_sel_c, wb_sel_c;
  logic [3:0] alu_ctrl_c;

  // Instruction class straight from the IR opcode field
  logic is_r, is_i, is_ld, is_st, is_br, is_jalr, op_ok;
  assign is_r    = (bus.opcode == OP_R);
  assign is_i    = (bus.opcode == OP_I);
  assign is_ld   = (bus.opcode == OP_LD);
  assign is_st   = (bus.opcode == OP_ST);
  assign is_br   = (bus.opcode == OP_BR);
  assign is_jalr = (bus.opcode == OP_JALR);
  assign op_ok   = is_r | is_i | is_ld | is_st | is_br | is_jalr;

  // ALU operation for register/immediate arithmetic; SUB exists only in R form
  logic [3:0] alu_op;
  logic       alu_ok;
  always_comb begin
    alu_op = ALU_ADD;
    alu_ok = 1'b1;
    case (bus.funct3)
      3'b000:  alu_op = (is_r && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b001:  alu_op = ALU_SLL;
      3'b101:  alu_op = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b010:  alu_op = ALU_SLT;
      default: alu_ok = 1'b0;
    endcase
  end

  // Branch condition from the SUB flags of rs1 - rs2
  logic br_f3_ok, br_taken;
  always_comb begin
    br_f3_ok = 1'b1;
    br_taken = 1'b0;
    case (bus.funct3)
      3'b000:  br_taken = bus.alu_zero;
      3'b001:  br_taken = ~bus.alu_zero;
      3'b100:  br_taken = bus.alu_lt;
      3'b101:  br_taken = ~bus.alu_lt;
      default: br_f3_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = PC_PLUS4;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    alu_src_b_c = 1'b0;
    alu_ctrl_c  = ALU_ADD;
    reg_write_c = 1'b0;
    wb_sel_c    = WB_ALU;
    retire_c    = 1'b0;
    illegal_c   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!op_ok || (is_br && !br_f3_ok)) state_d = ST_TRAP;
        else                                state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_r || is_i) begin
          if (alu_ok) begin
            alu_ctrl_c  = alu_op;
            alu_src_b_c = is_i;
            state_d     = ST_WB;
          end else begin
            state_d = ST_TRAP;
          end
        end else if (is_ld || is_st) begin
          alu_src_b_c = 1'b1;
          state_d     = ST_MEM;
        end else if (is_jalr) begin
          alu_src_b_c = 1'b1;
          state_d     = ST_WB;
        end else if (is_br) begin
          alu_ctrl_c = ALU_SUB;
          pc_write_c = 1'b1;
          retire_c   = 1'b1;
          pc_sel_c   = br_taken ? PC_BRANCH : PC_PLUS4;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_TRAP;
        end
      end

      // Address stays on the ALU result with EXEC controls held for the whole handshake
      ST_MEM: begin
        mem_req_c   = 1'b1;
        addr_sel_c  = 1'b1;
        mem_we_c    = is_st;
        alu_src_b_c = 1'b1;
        if (bus.mem_ready) begin
          if (is_st) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        state_d     = ST_FETCH;
        if (is_ld) begin
          wb_sel_c = WB_MEM;
        end else if (is_jalr) begin
          wb_sel_c    = WB_PC4;
          pc_sel_c    = PC_JALR;
          alu_src_b_c = 1'b1;
        end
      end

      ST_TRAP: illegal_c = 1'b1;

      default: state_d = ST_TRAP;
    endcase

    // Stall watchdog: a ready arriving in the last allowed cycle still completes
    if (mem_req_c && !bus.mem_ready && (tmo_cnt_q == CNT_W'(TIMEOUT - 1))) begin
      state_d = ST_TRAP;
    end

    if ((state_d != state_q) || bus.mem_ready) begin
      tmo_cnt_d = '0;
    end else if (mem_req_c) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  // Reset masks every control so an aborted instruction cannot commit
  assign bus.ir_write  = rst & ir_write_c;
  assign bus.pc_write  = rst & pc_write_c;
  assign bus.pc_sel    = rst ? pc_sel_c : 2'd0;
  assign bus.mem_req   = rst & mem_req_c;
  assign bus.mem_we    = rst & mem_we_c;
  assign bus.addr_sel  = rst & addr_sel_c;
  assign bus.alu_src_b = rst & alu_src_b_c;
  assign bus.alu_ctrl  = rst ? alu_ctrl_c : 4'd0;
  assign bus.reg_write = rst & reg_write_c;
  assign bus.wb_sel    = rst ? wb_sel_c : 2'd0;
  assign bus.retire    = rst & retire_c;
  assign bus.illegal   = rst & illegal_c;
  assign bus.state_o   = rst ? 3'(state_q) : 3'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver plays IR register and memory and
// queues per-instruction expectations; a negedge monitor checks each completion.
module tb_multicycle_ctrl;

  localparam int TMO = 8;
  localparam int TRAP_OUTS = 15;

  localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4, CL_JALR = 5, CL_BAD = 6;

  typedef struct {
    bit trap;
    int cycles;
    int rw;
    int wb;
    int psel;
    int ret_alu;
    int ret_srcb;
    int ex_alu;
    int ex_srcb;
    int we;
    int memc;
  } rec_t;

  logic clk;
  logic rst;
  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];

  int alu_tab [8] = '{0, 5, 8, -1, 4, 6, 3, 2};
  logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};

  logic [19:0] outs;
  assign outs = {bus.ir_write, bus.pc_write, bus.pc_sel, bus.mem_req, bus.mem_we, bus.addr_sel,
                 bus.alu_src_b, bus.alu_ctrl, bus.reg_write, bus.wb_sel, bus.retire,
                 bus.illegal, bus.state_o};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return CL_R;
      7'b0010011: return CL_I;
      7'b0000011: return CL_LD;
      7'b0100011: return CL_ST;
      7'b1100011: return CL_BR;
      7'b1100111: return CL_JALR;
      default:    return CL_BAD;
    endcase
  endfunction

  // Reference: what one instruction should look like, from its class and wait counts
  function automatic rec_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic lt, input int fw, input int wm);
    rec_t r;
    int   cls;
    int   a;
    bit   taken;
    r     = '{default: 0};
    cls   = cls_of(op);
    a     = alu_tab[f3];
    taken = 1'b0;
    if (fw >= TMO) begin
      r.trap = 1'b1; r.cycles = TMO; return r;
    end
    if (cls == CL_BAD || (cls == CL_BR && !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5}))) begin
      r.trap = 1'b1; r.cycles = fw + 2; return r;
    end
    case (cls)
      CL_R, CL_I: begin
        if (a < 0) begin
          r.trap = 1'b1; r.cycles = fw + 3; return r;
        end
        if (f3 == 3'd0 && cls == CL_R && f7)  r.ex_alu = 1;
        else if (f3 == 3'd5 && f7)            r.ex_alu = 7;
        else                                  r.ex_alu = a;
        r.ex_srcb = (cls == CL_I) ? 1 : 0;
        r.rw = 1;
        r.cycles = fw + 4;
      end
      CL_LD, CL_ST: begin
        if (wm >= TMO) begin
          r.trap = 1'b1; r.cycles = fw + 3 + TMO; return r;
        end
        r.ex_srcb = 1;
        r.memc = wm + 1;
        if (cls == CL_LD) begin
          r.rw = 1; r.wb = 1; r.cycles = fw + 5 + wm;
        end else begin
          r.we = 1; r.ret_srcb = 1; r.cycles = fw + 4 + wm;
        end
      end
      CL_JALR: begin
        r.ex_srcb = 1; r.ret_srcb = 1; r.rw = 1; r.wb = 2; r.psel = 1; r.cycles = fw + 4;
      end
      default: begin
        case (f3)
          3'd0:    taken = z;
          3'd1:    taken = !z;
          3'd4:    taken = lt;
          default: taken = !lt;
        endcase
        r.ex_alu = 1; r.ret_alu = 1; r.psel = taken ? 2 : 0; r.cycles = fw + 3;
      end
    endcase
    return r;
  endfunction

  task automatic step(input logic rdy);
    bus.mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step(1'($urandom_range(0, 1)));
    rst = 1'b1;
  endtask

  // abort_at: 0 = run to completion, k > 0 = assert reset in cycle k, < 0 = random k
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lt, input int fw, input int wm,
                       input int abort_at);
    rec_t e;
    int   cls;
    int   ms;
    int   ab;
    logic rdy;
    e   = model(op, f3, f7, z, lt, fw, wm);
    cls = cls_of(op);
    ms  = fw + 4;
    ab  = (abort_at < 0) ? int'($urandom_range(1, e.cycles)) : abort_at;
    exp_q.push_back(e);
    bus.alu_zero = z;
    bus.alu_lt   = lt;
    for (int k = 1; k <= e.cycles; k++) begin
      if (k == ab) begin
        do_reset(2);
        return;
      end
      if (k <= fw + 1)                                                  rdy = (k == fw + 1);
      else if ((cls == CL_LD || cls == CL_ST) && k >= ms && k <= ms + wm) rdy = (k == ms + wm);
      else                                                              rdy = 1'($urandom_range(0, 1));
      step(rdy);
      if (k == fw + 1) begin
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
      end
    end
    if (e.trap) begin
      repeat (4) step(1'($urandom_range(0, 1)));
      do_reset(3);
    end
  endtask

  // Monitor: per-instruction accumulation, compared at retire or trap entry
  int   icyc = 0, ex_alu = 0, ex_srcb = 0, memc = 0, we_seen = 0, rw_cnt = 0, irw_cnt = 0;
  bit   in_trap = 1'b0;
  rec_t mon_e;

  task automatic clear_acc();
    icyc = 0; ex_alu = 0; ex_srcb = 0; memc = 0; we_seen = 0; rw_cnt = 0; irw_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", int'(outs), 0);
      exp_q.delete();
      clear_acc();
      in_trap = 1'b0;
    end else if (in_trap) begin
      chk("trap_hold", int'(outs), TRAP_OUTS);
    end else begin
      icyc++;
      if (icyc == 1) begin
        chk("fetch_state", int'(bus.state_o), 0);
        chk("fetch_mem_req", int'(bus.mem_req), 1);
        chk("fetch_addr_sel", int'(bus.addr_sel), 0);
      end
      if (bus.state_o == 3'd2) begin
        ex_alu  = int'(bus.alu_ctrl);
        ex_srcb = int'(bus.alu_src_b);
      end
      if (bus.mem_req && bus.addr_sel) begin
        memc++;
        if (bus.mem_we) we_seen = 1;
      end
      rw_cnt  += int'(bus.reg_write);
      irw_cnt += int'(bus.ir_write);
      if (bus.retire || bus.state_o == 3'd7) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL completion: got an unexpected completion, expected none (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("trap_flag", int'(bus.illegal), int'(mon_e.trap));
          if (bus.state_o == 3'd7) begin
            chk("trap_cycles", icyc - 1, mon_e.cycles);
            chk("trap_outputs", int'(outs), TRAP_OUTS);
            in_trap = 1'b1;
          end else begin
            chk("cycles", icyc, mon_e.cycles);
            chk("pc_write", int'(bus.pc_write), 1);
            chk("reg_write", int'(bus.reg_write), mon_e.rw);
            chk("wb_sel", int'(bus.wb_sel), mon_e.wb);
            chk("pc_sel", int'(bus.pc_sel), mon_e.psel);
            chk("retire_alu_ctrl", int'(bus.alu_ctrl), mon_e.ret_alu);
            chk("retire_alu_src_b", int'(bus.alu_src_b), mon_e.ret_srcb);
            chk("exec_alu_ctrl", ex_alu, mon_e.ex_alu);
            chk("exec_alu_src_b", ex_srcb, mon_e.ex_srcb);
            chk("mem_we", we_seen, mon_e.we);
            chk("mem_cycles", memc, mon_e.memc);
            chk("reg_write_count", rw_cnt, mon_e.rw);
            chk("ir_write_count", irw_cnt, 1);
          end
        end
        clear_acc();
      end else if (icyc > 200) begin
        chk("watchdog_cycles", icyc, 0);
        clear_acc();
      end
    end
  end

  initial begin
    logic [6:0] op;
    int         fw;
    int         wm;
    clk = 1'b0;
    rst = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.alu_zero = 1'b0; bus.alu_lt = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b1;

    issue(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // addi
    issue(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0);  // sub
    issue(7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1, 0, 0);  // srai
    issue(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2, 0);  // lw, slow memory
    issue(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // sw
    issue(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 0);  // beq taken
    issue(7'b1100011, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // blt not taken
    issue(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // jalr
    issue(7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, TMO - 1, 0, 0);
    issue(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, TMO - 1, 0);
    issue(7'b0110011, 3'd6, 1'b0, 1'b0, 1'b0, 0, 0, 4);  // reset during WB
    issue(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // illegal opcode
    issue(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, TMO, 0, 0);  // fetch stall
    issue(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, TMO, 0);  // store stall
    issue(7'b0110011, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // bad ALU funct3
    issue(7'b1100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0);  // bad branch funct3

    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 15) < 14) ? ops[$urandom_range(0, 5)] : 7'($urandom);
      fw = ($urandom_range(0, 19) == 0) ? (($urandom_range(0, 1) == 1) ? TMO - 1 : TMO + 1)
                                        : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 19) == 0) ? (($urandom_range(0, 1) == 1) ? TMO - 1 : TMO + 1)
                                        : int'($urandom_range(0, 3));
      issue(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), fw, wm,
            ($urandom_range(0, 24) == 0) ? -1 : 0);
    end

    step(1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
